register_serializer: RTL
========================

# register_serializer

Parallel-to-serial transmitter that reads one WIDTH-bit word from a parallel register stage and shifts it out one bit per clock, LSB first. It is the unloading end of the 8-bit register datapath: the register holds a word, and this block accepts it through a valid/ready handshake and drives it onto a single serial line. A one-cycle done pulse marks the end of each frame. An optional even-parity bit can be appended.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  parallel word, sampled only on an accepted load
- load_valid  input  1  source offers din this cycle
- load_ready  output  1  block can accept a word; = (state==IDLE) && !rst
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a frame bit this cycle
- done  output  1  one-cycle pulse after the last frame bit

## Operation
- States: IDLE, SHIFT, PAR. PAR exists only with the parity macro.
- IDLE:
  - load_ready=1, sout=0, sout_valid=0.
  - On a clock edge with load_valid=1: shreg<=din, cnt<=0, par<=^din, then go to SHIFT.
- SHIFT:
  - sout=shreg[0], sout_valid=1, load_ready=0.
  - Each edge: shreg<=shreg>>1 (zero fill), cnt<=cnt+1.
  - At cnt==WIDTH-1 the next state is PAR if parity is enabled, otherwise IDLE with done<=1.
- PAR: sout=par, sout_valid=1. Next edge: go to IDLE with done<=1.
- load_valid while not in IDLE is ignored. din is never resampled mid-frame.
- cnt is $clog2(WIDTH) bits wide and saturates logically at WIDTH-1. It never wraps inside a frame.
- done is registered. It is high for exactly the first IDLE cycle after a frame and low otherwise.
- Reset values: state=IDLE, shreg=0, cnt=0, par=0, done=0. While rst=1: sout=0, sout_valid=0, load_ready=0.
- Reset asserted mid-frame aborts immediately. The remaining bits are dropped and done does not pulse.

## Timing
- Word accepted at edge k → bit 0 valid in the cycle after edge k. Bit i is valid in cycle k+1+i.
- Parity bit, when enabled: cycle k+1+WIDTH.
- done, with F = WIDTH (or WIDTH+1 with parity): high in cycle k+1+F, and load_ready=1 in that same cycle.
- Back-to-back loads (load_valid held high): a new word can be accepted at the edge ending the done cycle. This leaves exactly one sout_valid=0 cycle between frames.
- Frame period: WIDTH+1 cycles without parity, WIDTH+2 with parity.

## Configuration
- SERIALIZER_PARITY_EN
  - Defined: PAR state is compiled in, and an even-parity bit (XOR of the accepted din) follows the data bits.
  - Undefined: PAR state and par register are absent; the frame is WIDTH bits.
- All other behaviour is identical in both builds.

## Structure
- Shared package register_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, PAR} ser_state_t
  - localparam DATA_W = 8, used as the default for WIDTH
- One natural sub-module: mod_counter, the bit counter.
  - Inputs: clear, enable, clk, rst.
  - Output: cnt, plus a terminal flag at WIDTH-1.
- The shift register and FSM stay in register_serializer.

## Test plan
- Reset: hold rst=1 for 3 cycles → sout=0, sout_valid=0, done=0, load_ready=0. After release: load_ready=1.
- Load 8'b11001111 → sout sequence 1,1,1,1,0,0,1,1 in cycles k+1..k+8, then done=1 in the next cycle. With SERIALIZER_PARITY_EN, a parity bit 0 is inserted before done.
- Load 8'b10001001 with parity enabled → bits 1,0,0,1,0,0,0,1, then parity 1, then done. Without parity, done follows the 8th bit.
- Hold load_valid=1 with din=8'b11111111, then 8'b00000001 → two frames separated by exactly one sout_valid=0 cycle. The second frame reads 1,0,0,0,0,0,0,0.
- Pulse load_valid with din=8'b00000000 during cycle k+3 of a frame of 8'b11001111 → it is ignored, and the first frame completes unchanged.
- Assert rst in cycle k+4 of a frame → outputs go to 0 asynchronously and no done pulse occurs. After release, a new load of 8'b00000001 serializes correctly.

Source files
------------

// File: rtl/register_pkg.sv
// Shared types and widths for the 8-bit register datapath.
package register_pkg;

    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, PAR} ser_state_t;

endpackage

// File: rtl/register_serializer_mod_counter.sv
// Bit counter for register_serializer: clears on load, counts while shifting,
// holds at WIDTH-1 and flags that terminal value.
module mod_counter #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(WIDTH - 1));

    // Saturating count so a non-power-of-two WIDTH never wraps mid-frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !last) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/register_serializer.sv
// Parallel-to-serial transmitter, LSB first, with valid/ready load and done pulse.
// Optional even-parity bit after the data bits: define SERIALIZER_PARITY_EN.
module register_serializer
    import register_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ser_state_t       state;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             last;
    logic [CW-1:0]    cnt_unused;
`ifdef SERIALIZER_PARITY_EN
    logic             par;
`endif

    assign accept = (state == IDLE) && load_valid;

    mod_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept),
        .enable (state == SHIFT),
        .cnt    (cnt_unused),
        .last   (last)
    );

    // Frame sequencing; done is high only in the first IDLE cycle after a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= din;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg <= shreg >> 1;
                    if (last) begin
`ifdef SERIALIZER_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PAR: begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^din;
        end
    end
`endif

    // Line outputs decode the registered state; reset forces them low at once
    always_comb begin
        sout       = 1'b0;
        sout_valid = 1'b0;
        load_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:  load_ready = 1'b1;
                SHIFT: begin
                    sout       = shreg[0];
                    sout_valid = 1'b1;
                end
`ifdef SERIALIZER_PARITY_EN
                PAR: begin
                    sout       = par;
                    sout_valid = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
